// File: rtl/run_dump_pkg.sv
// Shared types and constants for the run-control / state-dump sequencer.
package run_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        RD,
        SEND,
        DONE
    } state_e;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_BUDGET = 2'b01;
    localparam logic [1:0] CAUSE_IDLE   = 2'b10;

endpackage

// File: rtl/run_dump_ctrl_if.sv
// Debug read port plus back-pressured dump stream between the sequencer and the harness.
interface run_dump_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 6
);

    logic              dbg_sel_o;
    logic [IDX_W-1:0]  dbg_addr_o;
    logic [DATA_W-1:0] dbg_data_i;
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [DATA_W-1:0] dump_data_o;
    logic [IDX_W-1:0]  dump_idx_o;

    modport master (
        output dbg_sel_o,
        output dbg_addr_o,
        input  dbg_data_i,
        output dump_valid_o,
        input  dump_ready_i,
        output dump_data_o,
        output dump_idx_o
    );

    modport slave (
        input  dbg_sel_o,
        input  dbg_addr_o,
        output dbg_data_i,
        input  dump_valid_o,
        output dump_ready_i,
        input  dump_data_o,
        input  dump_idx_o
    );

endinterface

// File: rtl/run_halt_det.sv
// Run-cycle budget counter and PC-stall halt detector; raises stop while enabled.
module run_halt_det
    import run_dump_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MAX_CYCLES = 150,
    parameter int unsigned IDLE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] pc,
    output logic              stop,
    output logic [1:0]        cause,
    output logic [31:0]       cycle_cnt
);

    logic [ADDR_W-1:0] pc_prev;
    logic [31:0]       idle_cnt;
    logic [31:0]       cycle_q;
    logic              pc_same;
    logic              budget_hit;
    logic              idle_hit;

    assign pc_same    = (pc == pc_prev);
    assign budget_hit = en && (cycle_q == 32'(MAX_CYCLES - 1));
    assign idle_hit   = en && pc_same && (idle_cnt == 32'(IDLE_LIMIT - 1));

    assign stop      = budget_hit || idle_hit;
    assign cause     = (budget_hit ? CAUSE_BUDGET : CAUSE_NONE) |
                       (idle_hit ? CAUSE_IDLE : CAUSE_NONE);
    assign cycle_cnt = cycle_q;

    // pc_prev tracks the PC every cycle so the first RUN cycle compares against IDLE's PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_prev  <= '0;
            idle_cnt <= '0;
            cycle_q  <= '0;
        end else begin
            pc_prev <= pc;
            if (en) begin
                if (cycle_q != '1) begin
                    cycle_q <= cycle_q + 32'd1;
                end
                idle_cnt <= pc_same ? idle_cnt + 32'd1 : '0;
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/run_dump_ctrl.sv
// Run-control and state-dump sequencer: run the CPU, stop on budget/idle, stream regs then memory.
// Optional running checksum is enabled by defining RUN_DUMP_CHECKSUM_EN.
module run_dump_ctrl
    import run_dump_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_CNT    = 32,
    parameter int unsigned MEM_WORDS  = 32,
    parameter int unsigned MAX_CYCLES = 150,
    parameter int unsigned IDLE_LIMIT = 8,
    parameter int unsigned IDX_W      = $clog2(REG_CNT + MEM_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      pc_i,
    output logic                   cpu_en_o,
    run_dump_ctrl_if.master        bus,
    output logic                   done_o,
    output logic [1:0]             halt_cause_o,
    output logic [31:0]            cycle_cnt_o,
    output logic [DATA_W-1:0]      checksum_o
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(REG_CNT + MEM_WORDS - 1);
    localparam logic [IDX_W-1:0] RegBase = IDX_W'(REG_CNT);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  k_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        cause_q;
    logic              stop;
    logic [1:0]        cause;
    logic              in_run;
    logic              beat_fire;
    logic              mem_sel;

    assign in_run    = (state_q == RUN);
    assign beat_fire = (state_q == SEND) && bus.dump_ready_i;
    assign mem_sel   = (k_q >= RegBase);

    run_halt_det #(
        .ADDR_W    (ADDR_W),
        .MAX_CYCLES(MAX_CYCLES),
        .IDLE_LIMIT(IDLE_LIMIT)
    ) u_halt_det (
        .clk      (clk),
        .rst      (rst),
        .en       (in_run),
        .pc       (pc_i),
        .stop     (stop),
        .cause    (cause),
        .cycle_cnt(cycle_cnt_o)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN:  if (stop) state_d = RD;
            RD:   state_d = SEND;
            SEND: if (bus.dump_ready_i) state_d = (k_q == LastIdx) ? DONE : RD;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            if (in_run && stop) begin
                cause_q <= cause;
            end
            if (state_q == RD) begin
                data_q <= bus.dbg_data_i;
                idx_q  <= k_q;
            end
            if (beat_fire) begin
                k_q <= k_q + IDX_W'(1);
            end
        end
    end

`ifdef RUN_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else if (beat_fire) begin
            csum_q <= csum_q + data_q;
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

    assign cpu_en_o         = in_run;
    assign done_o           = (state_q == DONE);
    assign halt_cause_o     = cause_q;
    assign bus.dbg_sel_o    = mem_sel;
    assign bus.dbg_addr_o   = mem_sel ? (k_q - RegBase) : k_q;
    // valid is decoded from state so an asynchronous reset drops it immediately
    assign bus.dump_valid_o = (state_q == SEND);
    assign bus.dump_data_o  = data_q;
    assign bus.dump_idx_o   = idx_q;

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Scoreboard bench for run_dump_ctrl: budget/idle/simultaneous stops, full-rate and stalled dumps.
module tb_run_dump_ctrl;

    localparam int unsigned HOLD_START = 18;
    localparam int unsigned IDLE_LIM   = 8;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] pc_a = '0;
    logic [31:0] pc_b = 32'h100;
    logic        ready_a = 1'b0;
    logic        ready_b = 1'b1;
    logic [31:0] regs [8];
    logic [31:0] mem  [8];

    logic        cpu_en_a, done_a, cpu_en_b, done_b;
    logic [1:0]  cause_a, cause_b;
    logic [31:0] cyc_a, cyc_b, csum_a, csum_b;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    logic [31:0] exp_csum;

    always #5 clk = ~clk;

    run_dump_ctrl_if #(.DATA_W(32), .IDX_W(3)) dif_a ();
    run_dump_ctrl_if #(.DATA_W(32), .IDX_W(3)) dif_b ();

    assign dif_a.dump_ready_i = ready_a;
    assign dif_b.dump_ready_i = ready_b;
    assign dif_a.dbg_data_i   = dif_a.dbg_sel_o ? mem[dif_a.dbg_addr_o] : regs[dif_a.dbg_addr_o];
    assign dif_b.dbg_data_i   = dif_b.dbg_sel_o ? mem[dif_b.dbg_addr_o] : regs[dif_b.dbg_addr_o];

    run_dump_ctrl #(
        .ADDR_W(32), .DATA_W(32), .REG_CNT(4), .MEM_WORDS(4), .MAX_CYCLES(150), .IDLE_LIMIT(8)
    ) u_a (
        .clk(clk), .rst(rst_a), .pc_i(pc_a), .cpu_en_o(cpu_en_a), .bus(dif_a),
        .done_o(done_a), .halt_cause_o(cause_a), .cycle_cnt_o(cyc_a), .checksum_o(csum_a)
    );

    run_dump_ctrl #(
        .ADDR_W(32), .DATA_W(32), .REG_CNT(4), .MEM_WORDS(4), .MAX_CYCLES(8), .IDLE_LIMIT(8)
    ) u_b (
        .clk(clk), .rst(rst_b), .pc_i(pc_b), .cpu_en_o(cpu_en_b), .bus(dif_b),
        .done_o(done_b), .halt_cause_o(cause_b), .cycle_cnt_o(cyc_b), .checksum_o(csum_b)
    );

    // Drives pc_a until RUN ends; mode 0 steps by 4, mode 1 climbs to 0x50 and holds it.
    task automatic wait_exit_a(input int mode, output int runs, output bit timeout);
        bit seen = 0;
        runs = 0;
        timeout = 1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (mode == 0) pc_a = pc_a + 32'd4;
            else pc_a = (i < int'(HOLD_START)) ? 32'(4 * (i + 2)) : 32'h50;
            @(negedge clk);
            if (cpu_en_a) begin
                seen = 1;
                runs++;
            end else if (seen) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic restart_a();
        rst_a = 1'b0;
        ready_a = 1'b0;
        pc_a = '0;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (cpu_en_a !== 1'b0 || done_a !== 1'b0 || cause_a !== 2'b00 || cyc_a !== 32'd0)
            begin errors++; $display("FAIL reset_ctrl: en=%b done=%b cause=%b cyc=%0d, want 0",
                                     cpu_en_a, done_a, cause_a, cyc_a); end
        checks++;
        if (dif_a.dump_valid_o !== 1'b0 || dif_a.dump_idx_o !== 3'd0 ||
            dif_a.dump_data_o !== 32'd0 || csum_a !== 32'd0)
            begin errors++; $display("FAIL reset_dump: valid=%b idx=%0d data=%0d csum=%0d, want 0",
                                     dif_a.dump_valid_o, dif_a.dump_idx_o, dif_a.dump_data_o,
                                     csum_a); end
        checks++;
        if (dif_a.dbg_sel_o !== 1'b0 || dif_a.dbg_addr_o !== 3'd0 || cpu_en_b !== 1'b0)
            begin errors++; $display("FAIL reset_dbg: sel=%b addr=%0d en_b=%b, want 0",
                                     dif_a.dbg_sel_o, dif_a.dbg_addr_o, cpu_en_b); end
    endtask

    task automatic test_budget();
        int runs;
        bit to;
        restart_a();
        wait_exit_a(0, runs, to);
        checks++;
        if (to || runs != 150)
            begin errors++; $display("FAIL budget_runs: got %0d timeout=%b, want 150", runs, to); end
        checks++;
        if (cause_a !== 2'b01)
            begin errors++; $display("FAIL budget_cause: got %b, want 01", cause_a); end
        checks++;
        if (cyc_a !== 32'd150)
            begin errors++; $display("FAIL budget_cycles: got %0d, want 150", cyc_a); end
    endtask

    // Entered at the negedge right after the RUN exit edge.
    task automatic test_dump(input bit bp);
        beat_t e;
        bit stall = 0;
        bit hit = 0;
        int n = 0;
        logic [31:0] sd = '0;
        logic [2:0] si = '0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            e.idx = 3'(k);
            e.data = (k < 4) ? 32'(k + 1) : 32'(10 * (k - 3));
            exp_q.push_back(e);
        end
        ready_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (done_a) begin hit = 1; break; end
            if (stall) begin
                checks++;
                if (dif_a.dump_valid_o !== 1'b1 || dif_a.dump_data_o !== sd ||
                    dif_a.dump_idx_o !== si)
                    begin errors++; $display("FAIL stall_hold: valid=%b idx=%0d data=%0d, want 1 %0d %0d",
                                             dif_a.dump_valid_o, dif_a.dump_idx_o,
                                             dif_a.dump_data_o, si, sd); end
            end
            if (dif_a.dump_valid_o === 1'b1) begin
                if (ready_a) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat: idx=%0d data=%0d, want none",
                                 dif_a.dump_idx_o, dif_a.dump_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (dif_a.dump_idx_o !== e.idx || dif_a.dump_data_o !== e.data)
                            begin errors++; $display("FAIL beat: idx=%0d data=%0d, want %0d %0d",
                                                     dif_a.dump_idx_o, dif_a.dump_data_o,
                                                     e.idx, e.data); end
                    end
                end
                stall = !ready_a;
                sd = dif_a.dump_data_o;
                si = dif_a.dump_idx_o;
            end else begin
                stall = 0;
            end
            @(posedge clk);
            #1;
            if (bp && (i % 3 == 2)) ready_a = ~ready_a;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL dump_timeout: done never rose, want done"); end
        if (!bp) begin
            checks++;
            if (n != 16) begin errors++; $display("FAIL done_latency: got %0d, want 16", n); end
        end
        checks++;
        if (exp_q.size() != 0)
            begin errors++; $display("FAIL beats_missing: %0d left, want 0", exp_q.size()); end
        checks++;
        if (csum_a !== exp_csum)
            begin errors++; $display("FAIL checksum: got %0d, want %0d", csum_a, exp_csum); end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || dif_a.dump_valid_o !== 1'b0 || cpu_en_a !== 1'b0)
            begin errors++; $display("FAIL done_hold: done=%b valid=%b en=%b, want 1 0 0",
                                     done_a, dif_a.dump_valid_o, cpu_en_a); end
    endtask

    task automatic test_idle();
        int runs;
        bit to;
        restart_a();
        wait_exit_a(1, runs, to);
        checks++;
        if (to || runs != int'(HOLD_START + IDLE_LIM + 1))
            begin errors++; $display("FAIL idle_runs: got %0d timeout=%b, want %0d", runs, to,
                                     HOLD_START + IDLE_LIM + 1); end
        checks++;
        if (cause_a !== 2'b10)
            begin errors++; $display("FAIL idle_cause: got %b, want 10", cause_a); end
        checks++;
        if (cyc_a !== 32'd27)
            begin errors++; $display("FAIL idle_cycles: got %0d, want 27", cyc_a); end
    endtask

    task automatic test_simultaneous();
        int runs = 0;
        bit seen = 0;
        bit to = 1;
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cpu_en_b) begin seen = 1; runs++; end
            else if (seen) begin to = 0; break; end
        end
        checks++;
        if (to || runs != 8 || cause_b !== 2'b11 || cyc_b !== 32'd8)
            begin errors++; $display("FAIL simultaneous: runs=%0d cause=%b cyc=%0d, want 8 11 8",
                                     runs, cause_b, cyc_b); end
        repeat (30) @(negedge clk);
        checks++;
        if (done_b !== 1'b1 || csum_b !== exp_csum)
            begin errors++; $display("FAIL simul_dump: done=%b csum=%0d, want 1 %0d",
                                     done_b, csum_b, exp_csum); end
    endtask

    task automatic test_back_pressure();
        int runs;
        bit to;
        restart_a();
        wait_exit_a(0, runs, to);
        checks++;
        if (to || cause_a !== 2'b01)
            begin errors++; $display("FAIL bp_run: timeout=%b cause=%b, want 0 01", to, cause_a); end
        test_dump(1'b1);
    endtask

    task automatic test_reset_mid_dump();
        int runs;
        bit to;
        bit found = 0;
        restart_a();
        wait_exit_a(0, runs, to);
        ready_a = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (dif_a.dump_valid_o === 1'b1 && dif_a.dump_idx_o === 3'd3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_find: beat 3 not seen, want seen"); end
        rst_a = 1'b0;
        #1;
        checks++;
        if (dif_a.dump_valid_o !== 1'b0 || cpu_en_a !== 1'b0 || done_a !== 1'b0 ||
            cause_a !== 2'b00 || cyc_a !== 32'd0 || dif_a.dump_idx_o !== 3'd0 ||
            dif_a.dump_data_o !== 32'd0 || csum_a !== 32'd0 || dif_a.dbg_addr_o !== 3'd0)
            begin errors++; $display("FAIL mid_reset: valid=%b en=%b cause=%b cyc=%0d idx=%0d, want 0",
                                     dif_a.dump_valid_o, cpu_en_a, cause_a, cyc_a,
                                     dif_a.dump_idx_o); end
        repeat (2) @(negedge clk);
        pc_a = '0;
        rst_a = 1'b1;
        wait_exit_a(0, runs, to);
        checks++;
        if (to || runs != 150 || cyc_a !== 32'd150)
            begin errors++; $display("FAIL mid_rerun: runs=%0d cyc=%0d, want 150 150", runs, cyc_a); end
        test_dump(1'b0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            regs[i] = (i < 4) ? 32'(i + 1) : 32'hDEAD_0000 + 32'(i);
            mem[i]  = (i < 4) ? 32'(10 * (i + 1)) : 32'hBEEF_0000 + 32'(i);
        end
`ifdef RUN_DUMP_CHECKSUM_EN
        exp_csum = 32'd110;
`else
        exp_csum = 32'd0;
`endif
        test_reset();
        test_budget();
        test_dump(1'b0);
        test_idle();
        test_simultaneous();
        test_back_pressure();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
